// File: rtl/reservation_station.sv
// reservation_station: operand buffer that collects dispatched ops, snoops the CDB and issues ready entries in index order
module reservation_station #(
  parameter int RS_ID_WIDTH   = 5,
  parameter int RS_OFFSET     = 0,
  parameter int RS_DEPTH      = 4,
  parameter int OPERANDS      = 3,
  parameter int PAYLOAD_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]        in_payload,
  input  logic [OPERANDS-1:0]             in_op_valid,
  input  logic [OPERANDS*32-1:0]          in_op_value,
  input  logic [OPERANDS*RS_ID_WIDTH-1:0] in_op_tag,
  output logic [RS_ID_WIDTH-1:0]          free_id,
  input  logic                            cdb_valid,
  input  logic [RS_ID_WIDTH-1:0]          cdb_id,
  input  logic [31:0]                     cdb_value,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PAYLOAD_WIDTH-1:0]        out_payload,
  output logic [OPERANDS*32-1:0]          out_op_value,
  output logic [RS_ID_WIDTH-1:0]          out_id
);
  localparam int IW = RS_DEPTH > 1 ? $clog2(RS_DEPTH) : 1;
  localparam int W  = RS_ID_WIDTH;
  logic [RS_DEPTH-1:0]      busy_q, busy_d, rdy;
  logic [PAYLOAD_WIDTH-1:0] pay_q [RS_DEPTH];
  logic [PAYLOAD_WIDTH-1:0] pay_d [RS_DEPTH];
  logic [OPERANDS-1:0]      opv_q [RS_DEPTH];
  logic [OPERANDS-1:0]      opv_d [RS_DEPTH];
  logic [31:0]              val_q [RS_DEPTH][OPERANDS];
  logic [31:0]              val_d [RS_DEPTH][OPERANDS];
  logic [W-1:0]             tag_q [RS_DEPTH][OPERANDS];
  logic [W-1:0]             tag_d [RS_DEPTH][OPERANDS];
  logic [IW-1:0]            fidx, sidx;
  logic                     acc, iss, cap;
  // Downward scan leaves the lowest free and lowest ready index; both default to slot 0
  always_comb begin
    rdy  = '0;
    fidx = '0;
    sidx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      rdy[i] = busy_q[i] & (&opv_q[i]);
      if (!busy_q[i]) fidx = IW'(i);
      if (rdy[i]) sidx = IW'(i);
    end
    in_ready    = ~&busy_q;
    out_valid   = |rdy;
    acc         = in_valid & in_ready;
    iss         = out_valid & out_ready;
    free_id     = W'(RS_OFFSET) + W'(fidx);
    out_id      = W'(RS_OFFSET) + W'(sidx);
    out_payload = pay_q[sidx];
    out_op_value = '0;
    for (int j = 0; j < OPERANDS; j++) out_op_value[j*32 +: 32] = val_q[sidx][j];
  end
  always_comb begin
    busy_d = busy_q;
    pay_d  = pay_q;
    opv_d  = opv_q;
    val_d  = val_q;
    tag_d  = tag_q;
    cap    = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int j = 0; j < OPERANDS; j++)
        if (busy_q[i] && !opv_q[i][j] && cdb_valid && tag_q[i][j] == cdb_id) begin
          opv_d[i][j] = 1'b1;
          val_d[i][j] = cdb_value;
        end
      if (iss && sidx == IW'(i)) busy_d[i] = 1'b0;
      if (acc && fidx == IW'(i)) begin
        busy_d[i] = 1'b1;
        pay_d[i]  = in_payload;
        for (int j = 0; j < OPERANDS; j++) begin
          cap         = !in_op_valid[j] && cdb_valid && in_op_tag[j*W +: W] == cdb_id;
          opv_d[i][j] = in_op_valid[j] | cap;
          val_d[i][j] = cap ? cdb_value : in_op_value[j*32 +: 32];
          tag_d[i][j] = in_op_tag[j*W +: W];
        end
      end
      if (flush) begin
        busy_d[i] = 1'b0;
        opv_d[i]  = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        pay_q[i] <= '0;
        opv_q[i] <= '0;
        for (int j = 0; j < OPERANDS; j++) begin
          val_q[i][j] <= '0;
          tag_q[i][j] <= '0;
        end
      end
    end else begin
      busy_q <= busy_d;
      pay_q  <= pay_d;
      opv_q  <= opv_d;
      val_q  <= val_d;
      tag_q  <= tag_d;
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios with hand-computed expectations for reservation_station
module tb_reservation_station;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, cdb_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [63:0] in_payload = 0, out_payload;
  logic [2:0]  in_op_valid = 0;
  logic [95:0] in_op_value = 0, out_op_value;
  logic [14:0] in_op_tag = 0;
  logic [4:0]  free_id, cdb_id = 0, out_id;
  logic [31:0] cdb_value = 0;
  int cmp = 0, errs = 0;
  always #5 clk = ~clk;
  reservation_station dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload(in_payload), .in_op_valid(in_op_valid), .in_op_value(in_op_value),
    .in_op_tag(in_op_tag), .free_id(free_id), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
    .cdb_value(cdb_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_payload(out_payload), .out_op_value(out_op_value), .out_id(out_id)
  );
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic disp(input logic [63:0] p, input logic [2:0] v, input logic [31:0] a, b, c,
                      input logic [4:0] ta, tb, tc);
    in_valid = 1; in_payload = p; in_op_valid = v;
    in_op_value = {c, b, a}; in_op_tag = {tc, tb, ta};
  endtask
  task automatic bcast(input logic [4:0] id, input logic [31:0] v);
    cdb_valid = 1; cdb_id = id; cdb_value = v;
  endtask
  task automatic idle;
    in_valid = 0; cdb_valid = 0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    cmp++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    cmp++; if (free_id !== 5'd0) begin errs++; $display("FAIL reset_free_id got %0d want 0", free_id); end
    cmp++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    cmp++; if (out_id !== 5'd0) begin errs++; $display("FAIL reset_out_id got %0d want 0", out_id); end
    cmp++; if (out_payload !== 64'd0) begin errs++; $display("FAIL reset_payload got %h want 0", out_payload); end
    cmp++; if (out_op_value !== 96'd0) begin errs++; $display("FAIL reset_ops got %h want 0", out_op_value); end
    rst_n = 1;
  endtask
  task automatic test_basic;
    out_ready = 1;
    cmp++; if (in_ready !== 1'b1 || free_id !== 5'd0) begin errs++; $display("FAIL basic_pre got rdy=%b id=%0d want 1/0", in_ready, free_id); end
    disp(64'h11, 3'b111, 5, 7, 0, 0, 0, 0);
    step; idle;
    cmp++; if (out_valid !== 1'b1 || out_id !== 5'd0) begin errs++; $display("FAIL basic_issue got v=%b id=%0d want 1/0", out_valid, out_id); end
    cmp++; if (out_op_value !== {32'd0, 32'd7, 32'd5}) begin errs++; $display("FAIL basic_ops got %h want 0/7/5", out_op_value); end
    cmp++; if (out_payload !== 64'h11 || free_id !== 5'd1) begin errs++; $display("FAIL basic_pay got %h fid=%0d want 11/1", out_payload, free_id); end
    step;
    cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || free_id !== 5'd0) begin errs++; $display("FAIL basic_free got v=%b r=%b fid=%0d want 0/1/0", out_valid, in_ready, free_id); end
  endtask
  task automatic test_fill;
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      cmp++; if (free_id !== 5'(k)) begin errs++; $display("FAIL fill_free_id got %0d want %0d", free_id, k); end
      disp(64'h20 + 64'(k), 3'b110, 0, 1, 2, 20, 0, 0);
      step;
    end
    idle;
    cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || free_id !== 5'd0) begin errs++; $display("FAIL fill_full got r=%b v=%b fid=%0d want 0/0/0", in_ready, out_valid, free_id); end
    bcast(20, 32'h99);
    step; idle;
    for (int k = 0; k < 4; k++) begin
      cmp++; if (out_valid !== 1'b1 || out_id !== 5'(k)) begin errs++; $display("FAIL fill_order got v=%b id=%0d want 1/%0d", out_valid, out_id, k); end
      cmp++; if (out_op_value[31:0] !== 32'h99 || out_payload !== 64'h20 + 64'(k)) begin errs++; $display("FAIL fill_data got a=%h p=%h want 99/%h", out_op_value[31:0], out_payload, 64'h20 + 64'(k)); end
      step;
    end
    cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL fill_drained got v=%b r=%b want 0/1", out_valid, in_ready); end
  endtask
  task automatic test_capture;
    out_ready = 1;
    disp(64'h33, 3'b101, 1, 0, 3, 0, 9, 0);
    bcast(9, 32'hAB);
    step; idle;
    cmp++; if (out_valid !== 1'b1 || out_id !== 5'd0) begin errs++; $display("FAIL capture_issue got v=%b id=%0d want 1/0", out_valid, out_id); end
    cmp++; if (out_op_value !== {32'd3, 32'hAB, 32'd1}) begin errs++; $display("FAIL capture_ops got %h want 3/ab/1", out_op_value); end
    step;
    cmp++; if (out_valid !== 1'b0) begin errs++; $display("FAIL capture_free got v=%b want 0", out_valid); end
  endtask
  task automatic test_priority;
    out_ready = 0;
    disp(64'h40, 3'b110, 0, 0, 0, 21, 0, 0); step;
    disp(64'h41, 3'b110, 0, 0, 0, 22, 0, 0); step;
    disp(64'h42, 3'b111, 4, 4, 4, 0, 0, 0); step; idle;
    cmp++; if (out_valid !== 1'b1 || out_id !== 5'd2) begin errs++; $display("FAIL prio_hold got v=%b id=%0d want 1/2", out_valid, out_id); end
    step;
    cmp++; if (out_id !== 5'd2 || out_payload !== 64'h42) begin errs++; $display("FAIL prio_stable got id=%0d p=%h want 2/42", out_id, out_payload); end
    bcast(21, 32'h55); step; idle;
    cmp++; if (out_id !== 5'd0 || out_payload !== 64'h40 || out_op_value[31:0] !== 32'h55) begin errs++; $display("FAIL prio_switch got id=%0d p=%h a=%h want 0/40/55", out_id, out_payload, out_op_value[31:0]); end
    out_ready = 1; step;
    cmp++; if (out_valid !== 1'b1 || out_id !== 5'd2) begin errs++; $display("FAIL prio_second got v=%b id=%0d want 1/2", out_valid, out_id); end
    step;
    cmp++; if (out_valid !== 1'b0 || free_id !== 5'd0) begin errs++; $display("FAIL prio_wait got v=%b fid=%0d want 0/0", out_valid, free_id); end
    bcast(22, 32'h66); step; idle;
    cmp++; if (out_valid !== 1'b1 || out_id !== 5'd1) begin errs++; $display("FAIL prio_last got v=%b id=%0d want 1/1", out_valid, out_id); end
    step;
  endtask
  task automatic test_back_to_back;
    out_ready = 0;
    disp(64'h50, 3'b110, 0, 0, 0, 23, 0, 0); step;
    disp(64'h51, 3'b111, 1, 2, 3, 0, 0, 0); step;
    disp(64'h52, 3'b110, 0, 0, 0, 23, 0, 0); step;
    disp(64'h53, 3'b110, 0, 0, 0, 23, 0, 0); step;
    cmp++; if (in_ready !== 1'b0 || out_id !== 5'd1) begin errs++; $display("FAIL b2b_full got r=%b id=%0d want 0/1", in_ready, out_id); end
    disp(64'h77, 3'b111, 8, 8, 8, 0, 0, 0);
    out_ready = 1; step; out_ready = 0;
    cmp++; if (in_ready !== 1'b1 || free_id !== 5'd1 || out_valid !== 1'b0) begin errs++; $display("FAIL b2b_freed got r=%b fid=%0d v=%b want 1/1/0", in_ready, free_id, out_valid); end
    step; idle;
    cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_id !== 5'd1 || out_payload !== 64'h77) begin errs++; $display("FAIL b2b_land got r=%b v=%b id=%0d p=%h want 0/1/1/77", in_ready, out_valid, out_id, out_payload); end
    out_ready = 1; step; out_ready = 0;
  endtask
  task automatic test_flush;
    cmp++; if (in_ready !== 1'b1 || free_id !== 5'd1 || out_valid !== 1'b0) begin errs++; $display("FAIL flush_pre got r=%b fid=%0d v=%b want 1/1/0", in_ready, free_id, out_valid); end
    flush = 1; step; flush = 0;
    cmp++; if (in_ready !== 1'b1 || free_id !== 5'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL flush_clear got r=%b fid=%0d v=%b want 1/0/0", in_ready, free_id, out_valid); end
    out_ready = 1;
    bcast(23, 32'hDEAD); step; idle;
    cmp++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_stale_cdb got v=%b want 0", out_valid); end
    bcast(30, 32'h1); step; idle;
    cmp++; if (out_valid !== 1'b0 || free_id !== 5'd0) begin errs++; $display("FAIL flush_unmatched got v=%b fid=%0d want 0/0", out_valid, free_id); end
  endtask
  task automatic test_async_reset;
    out_ready = 0;
    disp(64'h60, 3'b110, 0, 0, 0, 24, 0, 0); step;
    disp(64'h61, 3'b111, 1, 1, 1, 0, 0, 0); step; idle;
    cmp++; if (free_id !== 5'd2 || out_id !== 5'd1) begin errs++; $display("FAIL areset_pre got fid=%0d id=%0d want 2/1", free_id, out_id); end
    #2 rst_n = 0; #1;
    cmp++; if (free_id !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL areset_now got fid=%0d v=%b r=%b want 0/0/1", free_id, out_valid, in_ready); end
    @(negedge clk); rst_n = 1;
    out_ready = 1; bcast(24, 32'h7); step; idle;
    cmp++; if (out_valid !== 1'b0) begin errs++; $display("FAIL areset_stale got v=%b want 0", out_valid); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_fill;
    test_capture;
    test_priority;
    test_back_to_back;
    test_flush;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
